// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and pointer-compare helpers.
// Pointers carry one extra wrap bit above the RAM address.
package fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    // Full: address bits match, wrap bits differ.
    function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp,
                                      input int unsigned abits);
        logic [31:0] diff;
        diff = (wp ^ rp) & ((32'd1 << (abits + 1)) - 32'd1);
        return diff == (32'd1 << abits);
    endfunction

    function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp,
                                       input int unsigned abits);
        logic [31:0] diff;
        diff = (wp ^ rp) & ((32'd1 << (abits + 1)) - 32'd1);
        return diff == 32'd0;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM with synchronous write and registered, enabled read.
// No reset so the array maps onto block RAM.
module fifo_sync_ram #(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 16
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [DBITS-1:0] wdata,
    input  logic             re,
    input  logic [ABITS-1:0] raddr,
    output logic [DBITS-1:0] rdata
);

    logic [DBITS-1:0] mem [2**ABITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with pointer/flag control, registered read port (optional
// first-word-fall-through), programmable almost levels, count and sticky errors.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned ABITS  = 10,
    parameter int unsigned DBITS  = 16,
    parameter int unsigned FWFT   = 0,
    parameter int unsigned AF_LVL = 2**ABITS - 4,
    parameter int unsigned AE_LVL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wr_data,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [DBITS-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             almost_empty,
    output logic [ABITS:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam bit IS_FWFT = (FWFT == FIFO_FWFT);

    logic [ABITS:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic             full_q, empty_ram_q, af_q, ae_q, ovf_q, udf_q, vld_q, vld_d;
    logic             data_ok_q, wr_acc, ram_re, empty_out;
    logic [DBITS-1:0] ram_q;

    assign empty_out = IS_FWFT ? ~vld_q : empty_ram_q;

    always_comb begin
        wr_acc = wr_en & ~full_q & ~clr;
        if (IS_FWFT) begin
            // Prefetch into the output stage when it is vacant or being popped.
            ram_re = ~clr & ~empty_ram_q & (~vld_q | rd_en);
            vld_d  = ram_re | (vld_q & ~rd_en);
        end else begin
            ram_re = ~clr & rd_en & ~empty_ram_q;
            vld_d  = ram_re;
        end
        wr_ptr_d = wr_ptr_q + (ABITS+1)'(wr_acc);
        rd_ptr_d = rd_ptr_q + (ABITS+1)'(ram_re);
        count_d  = count_q + (ABITS+1)'(wr_acc) - (ABITS+1)'(ram_re);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_ram_q <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            vld_q       <= 1'b0;
            data_ok_q   <= 1'b0;
        end else if (clr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_ram_q <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            vld_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= ptr_full(32'(wr_ptr_d), 32'(rd_ptr_d), ABITS);
            empty_ram_q <= ptr_empty(32'(wr_ptr_d), 32'(rd_ptr_d), ABITS);
            af_q        <= 32'(count_d) >= AF_LVL;
            ae_q        <= 32'(count_d) <= AE_LVL;
            ovf_q       <= ovf_q | (wr_en & full_q);
            udf_q       <= udf_q | (rd_en & empty_out);
            vld_q       <= vld_d;
            data_ok_q   <= data_ok_q | ram_re;
        end
    end

    fifo_sync_ram #(
        .ABITS (ABITS),
        .DBITS (DBITS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q[ABITS-1:0]),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (rd_ptr_q[ABITS-1:0]),
        .rdata (ram_q)
    );

    // The RAM read register has no reset; mask it until a word has been loaded.
    assign rd_data      = data_ok_q ? ram_q : '0;
    assign rd_valid     = vld_q;
    assign empty        = empty_out;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: standard-mode and FWFT instances, data checked
// through a scoreboard queue.
module tb_fifo_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_clr = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [7:0] s_wr_data = '0, s_rd_data;
    logic       s_full, s_af, s_rd_valid, s_empty, s_ae, s_ovf, s_udf;
    logic [4:0] s_count;
    logic       f_clr = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [7:0] f_wr_data = '0, f_rd_data;
    logic       f_full, f_af, f_rd_valid, f_empty, f_ae, f_ovf, f_udf;
    logic [4:0] f_count;

    int unsigned tests = 0;
    int unsigned failed = 0;
    logic [7:0]  sq[$];
    logic [7:0]  fq[$];

    always #5 clk = ~clk;

    fifo_sync #(.ABITS(4), .DBITS(8), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .clr(s_clr), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .full(s_full), .almost_full(s_af), .rd_en(s_rd_en), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf)
    );

    fifo_sync #(.ABITS(4), .DBITS(8), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(f_clr), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .full(f_full), .almost_full(f_af), .rd_en(f_rd_en), .rd_data(f_rd_data),
        .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] spop();
        return (sq.size() > 0) ? sq.pop_front() : 8'hxx;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int cyc;
        // Reset values
        step();
        chk("rst_full", s_full, 0);
        chk("rst_af", s_af, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_ae", s_ae, 1);
        chk("rst_valid", s_rd_valid, 0);
        chk("rst_data", s_rd_data, 0);
        chk("rst_count", s_count, 0);
        chk("rst_ovf", s_ovf, 0);
        chk("rst_udf", s_udf, 0);
        chk("rst_f_empty", f_empty, 1);
        chk("rst_f_valid", f_rd_valid, 0);
        #3 rst_n = 1'b1;
        step();

        // Fill 16 words
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1'b1;
            s_wr_data = 8'(i);
            sq.push_back(8'(i));
            step();
            chk("fill_count", s_count, i + 1);
            chk("fill_af", s_af, (i + 1 >= 12) ? 1 : 0);
            chk("fill_ae", s_ae, (i + 1 <= 4) ? 1 : 0);
            chk("fill_full", s_full, (i == 15) ? 1 : 0);
            chk("fill_empty", s_empty, 0);
        end
        s_wr_data = 8'hEE;
        step();
        chk("ovf_set", s_ovf, 1);
        chk("ovf_count", s_count, 16);
        chk("ovf_full", s_full, 1);
        s_wr_en = 1'b0;

        // Drain with one-cycle read latency
        for (int i = 0; i < 16; i++) begin
            s_rd_en = 1'b1;
            step();
            chk("drain_valid", s_rd_valid, 1);
            chk("drain_data", s_rd_data, spop());
            chk("drain_count", s_count, 15 - i);
            chk("drain_empty", s_empty, (i == 15) ? 1 : 0);
        end
        step();
        chk("udf_set", s_udf, 1);
        chk("udf_valid", s_rd_valid, 0);
        chk("udf_hold", s_rd_data, 8'h0F);
        chk("udf_empty", s_empty, 1);
        s_rd_en = 1'b0;

        // Count 5, then 40 simultaneous cycles across two pointer wraps
        for (int i = 0; i < 5; i++) begin
            s_wr_en = 1'b1;
            s_wr_data = 8'h10 + 8'(i);
            sq.push_back(s_wr_data);
            step();
        end
        chk("pre_sim_count", s_count, 5);
        for (int i = 0; i < 40; i++) begin
            s_wr_en = 1'b1;
            s_rd_en = 1'b1;
            s_wr_data = 8'h80 + 8'(i);
            sq.push_back(s_wr_data);
            step();
            chk("sim_valid", s_rd_valid, 1);
            chk("sim_data", s_rd_data, spop());
            chk("sim_count", s_count, 5);
        end
        s_rd_en = 1'b0;

        // clr at count 9 with overflow set and a write pending
        for (int i = 0; i < 4; i++) begin
            s_wr_data = 8'h60 + 8'(i);
            step();
        end
        chk("pre_clr_count", s_count, 9);
        chk("pre_clr_ovf", s_ovf, 1);
        s_clr = 1'b1;
        s_wr_data = 8'h99;
        step();
        sq.delete();
        s_clr = 1'b0;
        s_wr_en = 1'b0;
        chk("clr_count", s_count, 0);
        chk("clr_empty", s_empty, 1);
        chk("clr_ae", s_ae, 1);
        chk("clr_ovf", s_ovf, 0);
        chk("clr_udf", s_udf, 0);
        chk("clr_valid", s_rd_valid, 0);
        s_wr_en = 1'b1;
        s_wr_data = 8'h31;
        step();
        s_wr_en = 1'b0;
        chk("post_clr_count", s_count, 1);
        s_rd_en = 1'b1;
        step();
        s_rd_en = 1'b0;
        chk("post_clr_data", s_rd_data, 8'h31);
        chk("post_clr_empty", s_empty, 1);

        // Write + read while full: read accepted, write dropped
        for (int i = 0; i < 16; i++) begin
            s_wr_en = 1'b1;
            s_wr_data = 8'h40 + 8'(i);
            sq.push_back(s_wr_data);
            step();
        end
        chk("refill_full", s_full, 1);
        s_rd_en = 1'b1;
        s_wr_data = 8'h77;
        step();
        s_wr_en = 1'b0;
        chk("wrfull_data", s_rd_data, spop());
        chk("wrfull_count", s_count, 15);
        chk("wrfull_ovf", s_ovf, 1);
        chk("wrfull_full", s_full, 0);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("tail_data", s_rd_data, spop());
        end
        s_rd_en = 1'b0;
        step();
        chk("tail_empty", s_empty, 1);
        chk("tail_udf", s_udf, 0);

        // FWFT: write at edge k visible after edge k+1
        f_wr_en = 1'b1;
        f_wr_data = 8'hA5;
        step();
        f_wr_en = 1'b0;
        chk("fw_k_valid", f_rd_valid, 0);
        chk("fw_k_empty", f_empty, 1);
        step();
        chk("fw_k1_valid", f_rd_valid, 1);
        chk("fw_k1_data", f_rd_data, 8'hA5);
        chk("fw_k1_empty", f_empty, 0);
        chk("fw_k1_count", f_count, 0);
        f_rd_en = 1'b1;
        step();
        f_rd_en = 1'b0;
        chk("fw_pop_valid", f_rd_valid, 0);
        chk("fw_pop_empty", f_empty, 1);

        // FWFT streaming: one word per cycle once primed
        pops = 0;
        cyc = 0;
        for (int c = 0; c < 20 && pops < 10; c++) begin
            f_wr_en = (c < 10);
            f_wr_data = 8'hB0 + 8'(c);
            f_rd_en = f_rd_valid;
            if (f_rd_valid) begin
                chk("fw_stream_data", f_rd_data, (fq.size() > 0) ? fq.pop_front() : 8'hxx);
                pops++;
            end
            if (f_wr_en) fq.push_back(f_wr_data);
            step();
            cyc = c + 1;
        end
        f_wr_en = 1'b0;
        f_rd_en = 1'b0;
        chk("fw_stream_pops", pops, 10);
        chk("fw_stream_cycles", cyc, 12);
        chk("fw_stream_empty", f_empty, 1);
        chk("fw_stream_udf", f_udf, 0);

        // Asynchronous reset between edges, mid-stream
        for (int i = 0; i < 3; i++) begin
            s_wr_en = 1'b1;
            s_wr_data = 8'hC0 + 8'(i);
            step();
        end
        s_wr_en = 1'b0;
        s_rd_en = 1'b1;
        step();
        s_rd_en = 1'b0;
        chk("pre_rst_data", s_rd_data, 8'hC0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", s_count, 0);
        chk("arst_empty", s_empty, 1);
        chk("arst_ae", s_ae, 1);
        chk("arst_data", s_rd_data, 0);
        chk("arst_valid", s_rd_valid, 0);
        chk("arst_full", s_full, 0);
        #2 rst_n = 1'b1;
        s_wr_en = 1'b1;
        s_wr_data = 8'hD1;
        step();
        s_wr_en = 1'b0;
        chk("post_rst_count", s_count, 1);
        s_rd_en = 1'b1;
        step();
        s_rd_en = 1'b0;
        chk("post_rst_valid", s_rd_valid, 1);
        chk("post_rst_data", s_rd_data, 8'hD1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
